seq_alu_datapath: RTL
=====================

SEQ_ALU_DATAPATH -- requirements
Module: seq_alu_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data/register width (>=2).
REQ-002 SHALL have parameter DEPTH, default 4, register-file entries (power of 2, >=2); AW = log2(DEPTH).
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports start in 1 (request operation); op in 3 (ALU opcode); src_a, src_b, dst in AW each (register addresses).
REQ-006 SHALL have ports ld_en in 1, ld_addr in AW, data_in in WIDTH (external register load).
REQ-007 SHALL have port out_en in 1, gates data_out.
REQ-008 SHALL have outputs busy 1, done 1, result WIDTH (last latched result), carry 1, zero 1, data_out WIDTH.

Function
REQ-009 SHALL implement FSM IDLE -> FETCH -> EXEC -> WB -> IDLE, one cycle per non-IDLE state.
REQ-010 SHALL accept start only in IDLE; capture op, src_a, src_b, dst on accept; start while busy ignored, not queued.
REQ-011 FETCH SHALL latch A=reg[src_a], B=reg[src_b] into operand registers.
REQ-012 EXEC SHALL latch result, carry, zero from ALU of A, B.
REQ-013 WB SHALL write result into reg[dst] and pulse done for exactly that cycle.
REQ-014 Latency: start accepted at edge N -> done high during cycle N+3; reg[dst] updated at edge ending WB; next start accepted in cycle N+4.
REQ-015 busy SHALL be high in FETCH, EXEC, WB; low in IDLE.
REQ-016 Opcodes: 0 PASS A; 1 ADD; 2 SUB (A-B); 3 AND; 4 OR; 5 XOR; 6 SHL1 A; 7 SHR1 A (logical).
REQ-017 Arithmetic SHALL wrap modulo 2^WIDTH; ADD carry = bit WIDTH of A+B; SUB carry = borrow (A<B unsigned); SHL1 carry = A[MSB]; SHR1 carry = A[0]; logic/PASS carry = 0.
REQ-018 zero SHALL be 1 iff latched result == 0.
REQ-019 ld_en SHALL write data_in to reg[ld_addr] only in IDLE; ignored while busy.
REQ-020 ld_en with start in same IDLE cycle: both take effect; FETCH SHALL see the loaded value.
REQ-021 src_a == src_b == dst SHALL be legal; operands are values before WB.
REQ-022 data_out SHALL equal result when out_en=1, else 0, combinationally.
REQ-023 result, carry, zero SHALL hold until the next EXEC.

Reset
REQ-024 rst_n=0 at an edge SHALL force IDLE, clear all registers, operands, result, carry, zero; busy=0, done=0.
REQ-025 Reset mid-operation SHALL abort with no WB write and no done pulse.
REQ-026 Reset SHALL take precedence over start and ld_en.

Structure
REQ-027 Shared package SHALL hold opcode enum (PASS..SHR1) and FSM state enum.
REQ-028 Combinational ALU SHALL be sub-module alu_core (WIDTH param; a, b, op -> y, carry).
REQ-029 Register file, operand/result registers and FSM SHALL reside in seq_alu_datapath; target 150-300 lines.

Verification (WIDTH=8, DEPTH=4)
REQ-030 Load r0=0xF0, r1=0x20; ADD r0,r1->r2 -> done at N+3, r2=0x10, carry=1, zero=0.
REQ-031 r0=0x05, r1=0x07; SUB r0,r1->r3 -> r3=0xFE, carry=1; SUB r1,r0 -> 0x02, carry=0.
REQ-032 XOR r1,r1->r1 (r1=0x55) -> r1=0x00, zero=1; out_en=0 -> data_out=0x00; out_en=1 -> 0x00 = result.
REQ-033 start pulsed during FETCH/EXEC and ld_en during busy -> ignored: single done, register file unchanged except dst.
REQ-034 ld_en r0=0x81 with start SHL1 r0->r1 same cycle -> r1=0x02, carry=1.
REQ-035 rst_n=0 during EXEC -> next cycle IDLE, busy=0, no done, all registers 0x00.

Source files
------------

// File: rtl/seq_alu_datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_datapath_pkg
//  Purpose  : Shared types for the sequential ALU datapath: the ALU opcode
//             encoding and the FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seq_alu_datapath_pkg;

   // Width of the opcode field carried on the op port.
   localparam int c_OP_W = 3;

   // ALU opcodes; values are fixed by the external op encoding.
   typedef enum logic [c_OP_W-1:0] {
      OP_PASS = 3'd0,   // y = A
      OP_ADD  = 3'd1,   // y = A + B
      OP_SUB  = 3'd2,   // y = A - B
      OP_AND  = 3'd3,   // y = A & B
      OP_OR   = 3'd4,   // y = A | B
      OP_XOR  = 3'd5,   // y = A ^ B
      OP_SHL1 = 3'd6,   // y = A << 1
      OP_SHR1 = 3'd7    // y = A >> 1 (logical)
   } alu_op_t;

   // Controller states; every non-idle state lasts exactly one cycle.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WB    = 2'd3
   } state_t;

endpackage : seq_alu_datapath_pkg
`default_nettype wire

// File: rtl/seq_alu_datapath_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Purely combinational ALU used by seq_alu_datapath.
//  Ports    : a, b   in  WIDTH  operands
//             op     in  3      opcode (alu_op_t)
//             y      out WIDTH  result, wraps modulo 2^WIDTH
//             carry  out 1      ADD carry-out, SUB borrow, shifted-out bit,
//                               0 for PASS and bitwise ops
//  Revision : 1.0 - initial release
// ============================================================================
module alu_core
   import seq_alu_datapath_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          op,
   output logic [WIDTH-1:0] y,
   output logic             carry
);

   // One extra bit on each arithmetic path: for the sum it is the carry,
   // for the difference it is set exactly when A < B (unsigned borrow).
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      y     = a;
      carry = 1'b0;
      case (op)
         OP_PASS: begin
            y     = a;
            carry = 1'b0;
         end
         OP_ADD: begin
            y     = w_sum[WIDTH-1:0];
            carry = w_sum[WIDTH];
         end
         OP_SUB: begin
            y     = w_diff[WIDTH-1:0];
            carry = w_diff[WIDTH];
         end
         OP_AND: begin
            y     = a & b;
            carry = 1'b0;
         end
         OP_OR: begin
            y     = a | b;
            carry = 1'b0;
         end
         OP_XOR: begin
            y     = a ^ b;
            carry = 1'b0;
         end
         OP_SHL1: begin
            y     = {a[WIDTH-2:0], 1'b0};
            carry = a[WIDTH-1];
         end
         OP_SHR1: begin
            y     = {1'b0, a[WIDTH-1:1]};
            carry = a[0];
         end
         default: begin
            y     = a;
            carry = 1'b0;
         end
      endcase
   end

endmodule : alu_core
`default_nettype wire

// File: rtl/seq_alu_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_datapath
//  Purpose  : Register-file datapath with a four-state sequencer
//             (IDLE -> FETCH -> EXEC -> WB) around a combinational ALU.
//  Ports    : clk            in  1      clock, rising edge
//             rst_n          in  1      synchronous active-low reset
//             start          in  1      request an operation (IDLE only)
//             op             in  3      ALU opcode
//             src_a, src_b   in  AW     operand register addresses
//             dst            in  AW     destination register address
//             ld_en          in  1      external register load (IDLE only)
//             ld_addr        in  AW     load address
//             data_in        in  WIDTH  load data
//             out_en         in  1      gates data_out
//             busy           out 1      high in FETCH/EXEC/WB
//             done           out 1      one-cycle pulse during WB
//             result         out WIDTH  last latched ALU result
//             carry, zero    out 1      flags latched with result
//             data_out       out WIDTH  result when out_en, else 0
//  Revision : 1.0 - initial release
// ============================================================================
module seq_alu_datapath
   import seq_alu_datapath_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    src_a,
   input  logic [AW-1:0]    src_b,
   input  logic [AW-1:0]    dst,
   input  logic             ld_en,
   input  logic [AW-1:0]    ld_addr,
   input  logic [WIDTH-1:0] data_in,
   input  logic             out_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic [WIDTH-1:0] data_out
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_load;

   // Instruction fields captured when start is accepted
   alu_op_t          r_op;
   logic [AW-1:0]    r_src_a;
   logic [AW-1:0]    r_src_b;
   logic [AW-1:0]    r_dst;

   // Operand and result registers
   logic [WIDTH-1:0] r_opnd_a;
   logic [WIDTH-1:0] r_opnd_b;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_zero;

   // Register file
   logic [WIDTH-1:0] r_regs [DEPTH];

   // ALU outputs
   logic [WIDTH-1:0] w_alu_y;
   logic             w_alu_carry;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and status outputs. A start seen outside IDLE is
   // simply dropped; nothing is queued.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            w_state_nxt = ST_WB;
         end
         ST_WB: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // External loads are honoured only while idle.
   assign w_load = (r_state == ST_IDLE) && ld_en;

   // ------------------------------------------------------------------
   // Instruction capture, operand fetch, result latch
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op     <= OP_PASS;
         r_src_a  <= '0;
         r_src_b  <= '0;
         r_dst    <= '0;
         r_opnd_a <= '0;
         r_opnd_b <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op    <= alu_op_t'(op);
            r_src_a <= src_a;
            r_src_b <= src_b;
            r_dst   <= dst;
         end
         // A load issued in the accept cycle has already landed in the
         // register file by now, so FETCH reads the freshly loaded value.
         if (r_state == ST_FETCH) begin
            r_opnd_a <= r_regs[r_src_a];
            r_opnd_b <= r_regs[r_src_b];
         end
         // Result and flags hold until the next EXEC.
         if (r_state == ST_EXEC) begin
            r_result <= w_alu_y;
            r_carry  <= w_alu_carry;
            r_zero   <= (w_alu_y == '0);
         end
      end
   end

   // ------------------------------------------------------------------
   // Register file: WB write-back and idle-time external load. The two
   // sources are state-exclusive, so no arbitration is required.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (r_state == ST_WB) begin
         r_regs[r_dst] <= r_result;
      end else if (w_load) begin
         r_regs[ld_addr] <= data_in;
      end
   end

   // ------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------
   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a     (r_opnd_a),
      .b     (r_opnd_b),
      .op    (r_op),
      .y     (w_alu_y),
      .carry (w_alu_carry)
   );

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign result   = r_result;
   assign carry    = r_carry;
   assign zero     = r_zero;
   assign data_out = out_en ? r_result : '0;

endmodule : seq_alu_datapath
`default_nettype wire
